// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer.
//   trap_state_e  : FSM state encoding used by trap_ctrl
//   CAUSE_ECALL_M : mcause value for an environment call from M-mode
//   cause_irq()   : builds an interrupt mcause (bit 31 set, code base+idx)
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_COMMIT,
        ST_REDIRECT,
        ST_IN_TRAP,
        ST_RETURN
    } trap_state_e;

    localparam logic [31:0] CAUSE_ECALL_M = 32'h0000_000B;

    // Interrupt causes carry the interrupt flag in bit 31; the remaining
    // bits hold the line's cause code.
    function automatic logic [31:0] cause_irq(input int unsigned base,
                                              input int unsigned idx);
        logic [30:0] code;
        code = 31'(base + idx);
        return {1'b1, code};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of every signal exchanged between trap_ctrl and its neighbours
// (pipeline, interrupt sources, CSR file).
//   master : the environment side (drives requests/CSR values, observes
//            flush, commit and redirect)
//   slave  : the trap_ctrl side
// Signals:
//   ecall, mret     one-cycle pulses from EX
//   irq_i, mie_i    level interrupt requests and their enables
//   global_ie       mstatus.MIE
//   pipe_empty      no valid instruction in ID/EX/MEM
//   mtvec_i, mepc_i current CSR values
//   flush, trap_commit, mcause_o, pc_load, pc_target, in_trap,
//   irq_pending_o, err_nested, flush_timeout   sequencer outputs
interface trap_ctrl_if #(
    parameter int NUM_IRQ = 4
) ();

    logic               ecall;
    logic [NUM_IRQ-1:0] irq_i;
    logic [NUM_IRQ-1:0] mie_i;
    logic               global_ie;
    logic               mret;
    logic               pipe_empty;
    logic [31:0]        mtvec_i;
    logic [31:0]        mepc_i;

    logic               flush;
    logic               trap_commit;
    logic [31:0]        mcause_o;
    logic               pc_load;
    logic [31:0]        pc_target;
    logic               in_trap;
    logic [NUM_IRQ-1:0] irq_pending_o;
    logic               err_nested;
    logic               flush_timeout;

    modport master (
        output ecall, irq_i, mie_i, global_ie, mret, pipe_empty,
               mtvec_i, mepc_i,
        input  flush, trap_commit, mcause_o, pc_load, pc_target, in_trap,
               irq_pending_o, err_nested, flush_timeout
    );

    modport slave (
        input  ecall, irq_i, mie_i, global_ie, mret, pipe_empty,
               mtvec_i, mepc_i,
        output flush, trap_commit, mcause_o, pc_load, pc_target, in_trap,
               irq_pending_o, err_nested, flush_timeout
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
//   req   : request vector
//   valid : at least one request is set
//   idx   : index of the lowest set request (0 when valid=0)
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scanning from the top down lets the lowest set bit overwrite any
    // higher one, so the final value is the lowest-index request.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer between the pipeline, the interrupt sources and the CSR
// file. Takes an ecall or the lowest-index eligible interrupt, flushes the
// pipeline, strobes the CSR file to latch mepc/mcause, redirects fetch to
// mtvec, blocks further traps until mret and then redirects fetch to mepc.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : trap_ctrl_if.slave carrying all request, CSR and output signals
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int NUM_IRQ        = 4,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter int FLUSH_MAX      = 8
) (
    input logic         clk,
    input logic         rst,
    trap_ctrl_if.slave  bus
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int CNT_W = $clog2(FLUSH_MAX + 1);

    trap_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [31:0]        cause_q, cause_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               is_irq_q, is_irq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;

    logic [NUM_IRQ-1:0] eligible;
    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;

    logic               flush;
    logic               trap_commit;
    logic [31:0]        mcause;
    logic               pc_load;
    logic [31:0]        pc_target;
    logic               in_trap;

    // Only registered pending bits count; a request is taken the cycle
    // after it is first seen.
    assign eligible = pending_q & bus.mie_i & {NUM_IRQ{bus.global_ie}};

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (eligible),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    // A new request on a line wins over the clear of that same line.
    assign pending_d = (pending_q & ~clr_mask) | bus.irq_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cause_q   <= '0;
            idx_q     <= '0;
            is_irq_q  <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
            idx_q     <= idx_d;
            is_irq_q  <= is_irq_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state and Moore outputs. ecall is only acted upon in IDLE (take)
    // and IN_TRAP (flag as nested); in the other states the instruction is
    // being squashed so the pulse is dropped.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        idx_d       = idx_q;
        is_irq_d    = is_irq_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        clr_mask    = '0;
        flush       = 1'b0;
        trap_commit = 1'b0;
        mcause      = '0;
        pc_load     = 1'b0;
        pc_target   = '0;
        in_trap     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ecall) begin
                    cause_d  = CAUSE_ECALL_M;
                    is_irq_d = 1'b0;
                    state_d  = ST_FLUSH;
                end else if (irq_valid) begin
                    cause_d  = cause_irq(32'(IRQ_CAUSE_BASE), 32'(irq_idx));
                    idx_d    = irq_idx;
                    is_irq_d = 1'b1;
                    state_d  = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                flush = 1'b1;
                if (bus.pipe_empty) begin
                    cnt_d   = '0;
                    state_d = ST_COMMIT;
                end else if (cnt_q == CNT_W'(FLUSH_MAX - 1)) begin
                    // Pipeline never drained; proceed anyway and record it.
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_COMMIT: begin
                flush       = 1'b1;
                trap_commit = 1'b1;
                mcause      = cause_q;
                if (is_irq_q) begin
                    clr_mask[idx_q] = 1'b1;
                end
                state_d = ST_REDIRECT;
            end

            ST_REDIRECT: begin
                flush     = 1'b1;
                pc_load   = 1'b1;
                pc_target = bus.mtvec_i & 32'hFFFF_FFFC;
                state_d   = ST_IN_TRAP;
            end

            ST_IN_TRAP: begin
                in_trap = 1'b1;
                if (bus.mret) begin
                    state_d = ST_RETURN;
                end else if (bus.ecall) begin
                    err_d = 1'b1;
                end
            end

            ST_RETURN: begin
                in_trap   = 1'b1;
                pc_load   = 1'b1;
                pc_target = bus.mepc_i;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.flush         = flush;
    assign bus.trap_commit   = trap_commit;
    assign bus.mcause_o      = mcause;
    assign bus.pc_load       = pc_load;
    assign bus.pc_target     = pc_target;
    assign bus.in_trap       = in_trap;
    assign bus.irq_pending_o = pending_q;
    assign bus.err_nested    = err_q;
    assign bus.flush_timeout = tmo_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl. Stimulus pushes the expected
// commit/redirect events (kind, value, cycle) into a scoreboard queue; a
// separate monitor pops and compares whenever trap_commit or pc_load is seen.
// Level outputs (flush, in_trap, pending, sticky flags) are checked inline.
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int NUM_IRQ = 4;

    typedef struct {
        bit          is_load;
        logic [31:0] value;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    trap_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

    trap_ctrl #(
        .NUM_IRQ        (NUM_IRQ),
        .IRQ_CAUSE_BASE (16),
        .FLUSH_MAX      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every commit or redirect must match the next queued event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.trap_commit || bus.pc_load) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_event: got commit=%0b load=%0b mcause=%h target=%h cyc=%0d required none",
                             bus.trap_commit, bus.pc_load, bus.mcause_o, bus.pc_target, cyc);
                end else begin
                    exp_t e;
                    logic [31:0] val;
                    e   = sb.pop_front();
                    val = bus.pc_load ? bus.pc_target : bus.mcause_o;
                    if ((bus.pc_load != e.is_load) || (val != e.value) || (cyc != e.cyc)) begin
                        errors++;
                        $display("[TB] FAIL %s: got load=%0b val=%h cyc=%0d required load=%0b val=%h cyc=%0d",
                                 e.name, bus.pc_load, val, cyc, e.is_load, e.value, e.cyc);
                    end
                end
            end
            checks++;
            if ((!bus.trap_commit && bus.mcause_o != 0) || (!bus.pc_load && bus.pc_target != 0)) begin
                errors++;
                $display("[TB] FAIL idle_zero: got mcause=%h target=%h required 0 when strobes low (cyc=%0d)",
                         bus.mcause_o, bus.pc_target, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expectEvent(input bit is_load, input logic [31:0] value,
                               input int c, input string name);
        exp_t e;
        e.is_load = is_load;
        e.value   = value;
        e.cyc     = c;
        e.name    = name;
        sb.push_back(e);
    endtask

    // Drive one cycle of pulse inputs, then return at the next drive point.
    task automatic applyStimulus(input logic e, input logic m,
                                 input logic [NUM_IRQ-1:0] irq);
        bus.ecall = e;
        bus.mret  = m;
        bus.irq_i = irq;
        tick();
        bus.ecall = 1'b0;
        bus.mret  = 1'b0;
        bus.irq_i = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h (cyc=%0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_flush"},       32'(bus.flush), 0);
        checkOutput({tag, "_commit"},      32'(bus.trap_commit), 0);
        checkOutput({tag, "_mcause"},      bus.mcause_o, 0);
        checkOutput({tag, "_pc_load"},     32'(bus.pc_load), 0);
        checkOutput({tag, "_pc_target"},   bus.pc_target, 0);
        checkOutput({tag, "_in_trap"},     32'(bus.in_trap), 0);
        checkOutput({tag, "_pending"},     32'(bus.irq_pending_o), 0);
        checkOutput({tag, "_err_nested"},  32'(bus.err_nested), 0);
        checkOutput({tag, "_timeout"},     32'(bus.flush_timeout), 0);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int t;
        int m;
        int nflush;

        bus.ecall      = 1'b0;
        bus.mret       = 1'b0;
        bus.irq_i      = '0;
        bus.mie_i      = '0;
        bus.global_ie  = 1'b0;
        bus.pipe_empty = 1'b1;
        bus.mtvec_i    = 32'h0000_0104;
        bus.mepc_i     = 32'h0000_0200;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        checkReset("reset");
        tick();
        rst = 1'b0;
        tick();

        // ecall with an empty pipe: flush t+1, commit t+2, load t+3, in_trap t+4
        t = cyc;
        expectEvent(1'b0, 32'h0000_000B, t + 2, "ecall_commit");
        expectEvent(1'b1, 32'h0000_0104, t + 3, "ecall_redirect");
        applyStimulus(1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("ecall_flush_t1", 32'(bus.flush), 1);
        checkOutput("ecall_not_in_trap_t1", 32'(bus.in_trap), 0);
        waitCyc(t + 4);
        @(negedge clk);
        checkOutput("ecall_in_trap_t4", 32'(bus.in_trap), 1);
        checkOutput("ecall_flush_off_t4", 32'(bus.flush), 0);
        checkOutput("ecall_no_timeout", 32'(bus.flush_timeout), 0);

        // Nested ecall inside the handler is flagged and otherwise ignored
        tick();
        applyStimulus(1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("nested_err", 32'(bus.err_nested), 1);
        checkOutput("nested_still_in_trap", 32'(bus.in_trap), 1);
        checkOutput("nested_no_flush", 32'(bus.flush), 0);

        // mret returns to mepc for one cycle, then IDLE
        tick();
        t = cyc;
        expectEvent(1'b1, 32'h0000_0200, t + 1, "mret_mepc");
        applyStimulus(1'b0, 1'b1, '0);
        @(negedge clk);
        checkOutput("return_in_trap", 32'(bus.in_trap), 1);
        tick();
        @(negedge clk);
        checkOutput("idle_after_return", 32'(bus.in_trap), 0);

        // Two interrupts at once: line 1 taken first, line 2 after mret
        tick();
        bus.mie_i     = 4'b1111;
        bus.global_ie = 1'b1;
        tick();
        t = cyc;
        expectEvent(1'b0, 32'h8000_0011, t + 3, "irq1_commit");
        expectEvent(1'b1, 32'h0000_0104, t + 4, "irq1_redirect");
        applyStimulus(1'b0, 1'b0, 4'b0110);
        @(negedge clk);
        checkOutput("irq_pending_set", 32'(bus.irq_pending_o), 32'h6);
        waitCyc(t + 3);
        @(negedge clk);
        checkOutput("irq_pending_at_commit", 32'(bus.irq_pending_o), 32'h6);
        waitCyc(t + 4);
        @(negedge clk);
        checkOutput("irq1_cleared", 32'(bus.irq_pending_o), 32'h4);
        tick();
        bus.mtvec_i = 32'h0000_0107;
        waitCyc(t + 6);
        m = cyc;
        expectEvent(1'b1, 32'h0000_0200, m + 1, "irq1_mret");
        expectEvent(1'b0, 32'h8000_0012, m + 4, "irq2_commit");
        expectEvent(1'b1, 32'h0000_0104, m + 5, "irq2_redirect_masked");
        applyStimulus(1'b0, 1'b1, '0);
        waitCyc(m + 5);
        @(negedge clk);
        checkOutput("irq2_cleared", 32'(bus.irq_pending_o), 0);
        waitCyc(m + 6);
        @(negedge clk);
        checkOutput("irq2_in_trap", 32'(bus.in_trap), 1);
        tick();
        t = cyc;
        expectEvent(1'b1, 32'h0000_0200, t + 1, "irq2_mret");
        applyStimulus(1'b0, 1'b1, '0);
        bus.mtvec_i   = 32'h0000_0104;
        bus.mie_i     = '0;
        bus.global_ie = 1'b0;
        tick();
        // mret in IDLE must be ignored (monitor flags any stray redirect)
        applyStimulus(1'b0, 1'b1, '0);

        // Masked line 0: by mie_i, then by global_ie; never taken
        bus.mie_i     = 4'b1110;
        bus.global_ie = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0001);
        nflush = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.flush) nflush++;
            tick();
        end
        bus.mie_i     = 4'b1111;
        bus.global_ie = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.flush) nflush++;
            tick();
        end
        @(negedge clk);
        checkOutput("masked_no_flush", 32'(nflush), 0);
        checkOutput("masked_pending0", 32'(bus.irq_pending_o[0]), 1);
        tick();
        bus.mie_i = '0;
        pulseReset();
        @(negedge clk);
        checkOutput("reset_clears_pending", 32'(bus.irq_pending_o), 0);
        tick();

        // Pipe never drains: exactly 8 FLUSH cycles, then commit, timeout flag
        bus.pipe_empty = 1'b0;
        t = cyc;
        expectEvent(1'b0, 32'h0000_000B, t + 9, "timeout_commit");
        expectEvent(1'b1, 32'h0000_0104, t + 10, "timeout_redirect");
        applyStimulus(1'b1, 1'b0, '0);
        nflush = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.flush && !bus.trap_commit && !bus.pc_load) nflush++;
            tick();
        end
        @(negedge clk);
        checkOutput("flush_cycles", 32'(nflush), 8);
        checkOutput("flush_timeout_set", 32'(bus.flush_timeout), 1);
        tick();
        bus.pipe_empty = 1'b1;
        t = cyc;
        expectEvent(1'b1, 32'h0000_0200, t + 1, "timeout_mret");
        applyStimulus(1'b0, 1'b1, '0);
        tick();

        // Reset in the middle of FLUSH
        bus.mie_i     = 4'b0111;
        bus.global_ie = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b1000);
        bus.pipe_empty = 1'b0;
        applyStimulus(1'b1, 1'b0, '0);
        @(negedge clk);
        checkOutput("midflush_flush", 32'(bus.flush), 1);
        tick();
        pulseReset();
        @(negedge clk);
        checkReset("rst_flush");
        bus.pipe_empty = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        checkOutput("rst_flush_stays_idle", 32'(bus.flush), 0);
        tick();

        // Reset while the handler is running
        t = cyc;
        expectEvent(1'b0, 32'h0000_000B, t + 2, "trap2_commit");
        expectEvent(1'b1, 32'h0000_0104, t + 3, "trap2_redirect");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 4'b1000);
        waitCyc(t + 5);
        @(negedge clk);
        checkOutput("pre_rst_in_trap", 32'(bus.in_trap), 1);
        checkOutput("pre_rst_pending", 32'(bus.irq_pending_o), 32'h8);
        tick();
        pulseReset();
        @(negedge clk);
        checkReset("rst_in_trap");
        repeat (5) tick();
        @(negedge clk);
        checkOutput("rst_in_trap_stays_idle", 32'(bus.in_trap), 0);
        checkOutput("scoreboard_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
